// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU slice.
//   IMEM_ADDR_W    : word-address width of the instruction memory (2^11 words)
//   loader_state_t : control states of the program loader (imem_loader)
//   is_loading()   : true while the loader owns the instruction memory
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned IMEM_ADDR_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        DONE,
        ERR
    } loader_state_t;

    function automatic logic is_loading(input loader_state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    endfunction

endpackage

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Fills the instruction memory from an 8-bit byte stream. The stream carries
// a little-endian 16-bit word count followed by the program bytes, packed
// little-endian into 32-bit words written to word addresses 0, 1, 2, ...
// While loading, the CPU is held via cpu_hold.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle pulse; begins a load from IDLE, DONE or ERR
//   in_data/in_valid: stream byte and its valid flag
//   in_ready        : loader accepts a byte (transfer = in_valid && in_ready)
//   mem_we          : one-cycle write strobe to the instruction memory
//   mem_addr        : word address of the write
//   mem_wdata       : word to write
//   busy, cpu_hold  : high while the header or payload is being received
//   done            : level, load completed
//   error           : level, header word count exceeds memory capacity
// -----------------------------------------------------------------------------
module imem_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // Word counter must reach 2^ADDR_W, hence one extra bit.
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [16:0] CAP   = 17'(1) << ADDR_W;

    loader_state_t     state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CNT_W-1:0]  words_q, words_d;   // words whose 4th byte was accepted
    logic [1:0]        idx_q, idx_d;       // byte position within current word
    logic [23:0]       asm_q, asm_d;       // lower three bytes of current word
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              words_left;
    logic              xfer;
    logic [15:0]       hdr_len;

    assign words_left = 32'(words_q) < 32'(len_q);

    // in_ready is a decode of registered state only, so xfer has no
    // combinational path from in_valid back to any output.
    assign in_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                       ((state_q == DATA) && words_left);
    assign xfer      = in_valid && in_ready;
    assign hdr_len   = {in_data, len_q[7:0]};

    assign busy      = is_loading(state_q);
    assign cpu_hold  = busy;
    assign done      = (state_q == DONE);
    assign error     = (state_q == ERR);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        words_d = words_q;
        idx_d   = idx_q;
        asm_d   = asm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // Address advances at the edge that ends each write strobe.
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_LO;
                    words_d = '0;
                    idx_d   = '0;
                    addr_d  = '0;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d = hdr_len;
                    if (hdr_len == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, hdr_len} > CAP) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if (idx_q == 2'd3) begin
                        wdata_d = {in_data, asm_q};
                        we_d    = 1'b1;
                        idx_d   = '0;
                        words_d = words_q + CNT_W'(1);
                    end else begin
                        // Bytes enter at the top and shift down, so after
                        // three bytes asm holds {b2, b1, b0}.
                        asm_d = {in_data, asm_q[23:8]};
                        idx_d = idx_q + 2'd1;
                    end
                end else if (!words_left) begin
                    // Only reached in the write cycle of the final word.
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            words_q <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            words_q <= words_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader. Expected words are computed from the
// transmitted byte stream with plain arithmetic; observed writes are collected
// from the memory write port.
// -----------------------------------------------------------------------------
module tb_imem_loader;
    import cpu_pkg::*;

    localparam int unsigned AW = IMEM_ADDR_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic          error;

    int unsigned   errors = 0;
    int unsigned   checks = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [7:0]    tx_q[$];
    logic [31:0]   exp_q[$];

    imem_loader #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one byte after 'gap' idle cycles; returns at the negedge
    // following the accepting clock edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        int unsigned n;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL handshake: in_ready=%b required 1 within 50 cycles", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Builds header + payload for n words of random data and the expected words.
    task automatic build_load(input int unsigned n);
        int unsigned b0, b1, b2, b3;
        tx_q.delete();
        exp_q.delete();
        tx_q.push_back(8'(n % 256));
        tx_q.push_back(8'(n / 256));
        for (int unsigned k = 0; k < n; k++) begin
            b0 = $urandom_range(255, 0);
            b1 = $urandom_range(255, 0);
            b2 = $urandom_range(255, 0);
            b3 = $urandom_range(255, 0);
            tx_q.push_back(8'(b0));
            tx_q.push_back(8'(b1));
            tx_q.push_back(8'(b2));
            tx_q.push_back(8'(b3));
            exp_q.push_back(32'(b0 + b1 * 256 + b2 * 65536 + b3 * 16777216));
        end
    endtask

    task automatic send_stream(input int unsigned gap, input bit rnd);
        for (int unsigned i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], rnd ? $urandom_range(2, 0) : gap);
        end
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h5A;
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: rdy/we/busy/hold/done/err=%b required 000000",
                     {in_ready, mem_we, busy, cpu_hold, done, error});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%0h wdata=%h required 0/0", mem_addr, mem_wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid: in_ready=%b busy=%b required 0/0", in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_two_word();
        logic [7:0] s[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h23, 8'h00, 8'h00, 8'h00};
        clear_writes();
        pulse_start();
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b1 || mem_addr !== '0) begin
            errors++;
            $display("FAIL start_resp: busy=%b hold=%b rdy=%b addr=%0h required 1/1/1/0",
                     busy, cpu_hold, in_ready, mem_addr);
        end
        for (int unsigned i = 0; i < 10; i++) begin
            send_byte(s[i], 0);
            if (i == 5) begin
                checks++;
                if (mem_we !== 1'b1 || mem_addr !== 11'd0 || mem_wdata !== 32'h13) begin
                    errors++;
                    $display("FAIL word0: we=%b addr=%0h data=%h required 1/0/00000013",
                             mem_we, mem_addr, mem_wdata);
                end
            end
        end
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 11'd1 || mem_wdata !== 32'h23 ||
            in_ready !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL word1: we=%b addr=%0h data=%h rdy=%b done=%b required 1/1/00000023/0/0",
                     mem_we, mem_addr, mem_wdata, in_ready, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL two_done: done=%b busy=%b hold=%b we=%b required 1/0/0/0",
                     done, busy, cpu_hold, mem_we);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL two_count: writes=%0d required 2", wr_addr.size());
        end
    endtask

    task automatic test_zero_len();
        clear_writes();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++;
        if (done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL zero_len: done=%b rdy=%b busy=%b err=%b required 1/0/0/0",
                     done, in_ready, busy, error);
        end
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (wr_addr.size() != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_writes: writes=%0d done=%b required 0/1", wr_addr.size(), done);
        end
    endtask

    task automatic test_max_len_header();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h08, 0);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL len_2048: err=%b busy=%b rdy=%b required 0/1/1", error, busy, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_oversize();
        int unsigned n;
        clear_writes();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h08, 0);
        checks++;
        if (error !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL oversize: err=%b rdy=%b busy=%b done=%b required 1/0/0/0",
                     error, in_ready, busy, done);
        end
        in_valid = 1'b1;
        in_data  = 8'hAA;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (error !== 1'b1 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL err_hold: err=%b writes=%0d required 1/0", error, wr_addr.size());
        end
        pulse_start();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL err_clear: err=%b busy=%b required 0/1", error, busy);
        end
        build_load(1);
        tx_q.delete(0);
        tx_q.delete(0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_stream(0, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_addr.size() != 1 || wr_addr[0] !== '0 || wr_data[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL err_recover: done=%b writes=%0d data=%h required 1/1/%h",
                     done, wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx, exp_q[0]);
        end
    endtask

    task automatic test_backpressure();
        int unsigned n;
        clear_writes();
        build_load(1);
        pulse_start();
        send_stream(1, 1'b0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_addr.size() != 1 || wr_addr[0] !== '0 || wr_data[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL backpressure: done=%b writes=%0d data=%h required 1/1/%h",
                     done, wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx, exp_q[0]);
        end
    endtask

    task automatic test_start_glitch();
        int unsigned n;
        clear_writes();
        build_load(2);
        pulse_start();
        for (int unsigned i = 0; i < 4; i++) send_byte(tx_q[i], 0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL glitch_state: busy=%b rdy=%b err=%b required 1/1/0", busy, in_ready, error);
        end
        for (int unsigned i = 4; i < tx_q.size(); i++) send_byte(tx_q[i], 0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (wr_addr.size() != 2) begin
            errors++;
            $display("FAIL glitch_count: writes=%0d required 2", wr_addr.size());
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                checks++;
                if (wr_addr[k] !== AW'(k) || wr_data[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL glitch_word%0d: addr=%0h data=%h required %0h/%h",
                             k, wr_addr[k], wr_data[k], k, exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int unsigned n;
        clear_writes();
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, mem_we, busy, cpu_hold, done, error} !== 6'b0 ||
            mem_addr !== '0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: flags=%b addr=%0h wdata=%h required 000000/0/0",
                     {in_ready, mem_we, busy, cpu_hold, done, error}, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        pulse_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h12, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_addr.size() != 1 || wr_addr[0] !== '0 || wr_data[0] !== 32'h12) begin
            errors++;
            $display("FAIL restart_load: done=%b writes=%0d data=%h required 1/1/00000012",
                     done, wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx);
        end
    endtask

    task automatic test_random_loads();
        int unsigned n, words;
        for (int unsigned it = 0; it < 4; it++) begin
            clear_writes();
            words = $urandom_range(6, 1);
            build_load(words);
            pulse_start();
            send_stream(0, 1'b1);
            n = 0;
            while (done !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            repeat (2) @(negedge clk);
            checks++;
            if (done !== 1'b1 || wr_addr.size() != words) begin
                errors++;
                $display("FAIL rand%0d_count: done=%b writes=%0d required 1/%0d",
                         it, done, wr_addr.size(), words);
            end else begin
                for (int unsigned k = 0; k < words; k++) begin
                    checks++;
                    if (wr_addr[k] !== AW'(k) || wr_data[k] !== exp_q[k]) begin
                        errors++;
                        $display("FAIL rand%0d_word%0d: addr=%0h data=%h required %0h/%h",
                                 it, k, wr_addr[k], wr_data[k], k, exp_q[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        test_reset();
        test_two_word();
        test_zero_len();
        test_max_len_header();
        test_oversize();
        test_backpressure();
        test_start_glitch();
        test_reset_mid_load();
        test_random_loads();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the 2048-word instruction memory from an 8-bit byte stream before the CPU runs. It accepts a little-endian 16-bit word-count header followed by the program bytes, assembles 32-bit little-endian words, and drives the instruction memory's write port at word addresses 0, 1, 2, …. While loading, it holds the CPU via `cpu_hold`. It is the writer counterpart of the combinational `instr_mem` read path, whose word-addressed `addr[10:0]`/`instr[31:0]` view it populates.

## Interface

- `ADDR_W`, 11: word-address width; capacity is 2^ADDR_W words.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; begins a load; honoured only in IDLE, DONE, ERR.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte; transfer occurs when `in_valid && in_ready` at the clock edge.
- `mem_we`  out  1  one-cycle write strobe to instruction memory.
- `mem_addr`  out  ADDR_W  word address for the write.
- `mem_wdata`  out  32  word to write.
- `busy`  out  1  high in LEN_LO, LEN_HI, DATA.
- `cpu_hold`  out  1  equals `busy`.
- `done`  out  1  level; high in DONE.
- `error`  out  1  level; high in ERR.

## Operation

- States:
  - IDLE: after reset.
  - LEN_LO: header byte 0 becomes `len[7:0]`.
  - LEN_HI: header byte 1 becomes `len[15:8]`.
  - DATA: payload bytes.
  - DONE, ERR: terminal until the next `start` or `rst`.
- IDLE/DONE/ERR + `start` → LEN_LO. The word counter, byte index, and `mem_addr` clear to 0.
- A `start` pulse in LEN_LO, LEN_HI, or DATA is ignored.
- LEN_HI on a transfer:
  - `len == 0` → DONE; no writes.
  - `len > 2^ADDR_W` → ERR.
  - Otherwise → DATA.
- DATA byte assembly:
  - Byte index i (0–3) goes to `word[8i+7:8i]`; byte 0 is the LSB.
  - On the 4th byte, the assembled word is registered into `mem_wdata`, and `mem_we` pulses in the next cycle at the current word index.
  - `mem_addr` increments after each write.
- Byte assembly uses a separate register from `mem_wdata`, so the next word's bytes may arrive during a `mem_we` cycle.
- Last word: `in_ready` drops in the cycle after its 4th byte is accepted. At the edge that ends its `mem_we` cycle, the state moves to DONE.
- ERR: `in_ready` is 0 and incoming bytes are not consumed. Recovery requires `start` or `rst`.
- `in_ready` is 1 in LEN_LO and LEN_HI, and in DATA while words remain outstanding. It is 0 in all other states.
- `rst` in any state:
  - Next cycle: IDLE, all outputs 0, partial word discarded.
  - Memory contents already written are untouched.

## Timing

- Reset values: `in_ready`, `mem_we`, `busy`, `cpu_hold`, `done`, `error` are 0; `mem_addr` and `mem_wdata` are 0.
- `start` at edge t → `busy = 1` and `in_ready = 1` in cycle t+1.
- The 4th byte of word n is accepted at edge t → `mem_we = 1`, `mem_addr = n`, `mem_wdata` valid for exactly cycle t+1.
- Final word: `done = 1` and `busy = 0` from cycle t+2.
- Minimum load time for N words: 2 + 4N + 1 cycles from the first header transfer to `done`, with `in_valid` held high.
- `in_valid` gaps stall the loader indefinitely; the state is held and there is no timeout.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Shared package `cpu_pkg`:
  - `IMEM_ADDR_W = 11`.
  - `loader_state_t` enum: IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR.
- Single flat module; no sub-module. Byte assembly is a 24-bit shift/position register plus a 2-bit index.
- The top level muxes `instr_mem` write access between the loader and other writers; `cpu_hold` gates the CPU's reset.

## Test plan

- Reset: assert `rst` 2 cycles → all outputs 0, state IDLE; `in_ready = 0` even with `in_valid = 1`.
- Two-word load:
  - Stimulus: `start`, then bytes 02 00 13 00 00 00 23 00 00 00.
  - Required: `mem_we` pulses at addr 0 with 0x00000013, then at addr 1 with 0x00000023.
  - `done = 1` two cycles after the last byte; exactly 2 write strobes total.
- Zero length: header 00 00 → DONE next cycle, no `mem_we`, `in_ready = 0`.
- Oversize: header 01 08 (2049) → `error = 1`, `in_ready = 0`, no writes. A following `start` clears `error`, and a 1-word load succeeds.
- Backpressure and glitches:
  - 1-word load with `in_valid` toggling every other cycle → same data and address as with continuous valid.
  - A `start` pulse mid-DATA has no effect.
- Reset mid-load: `rst` after 2 payload bytes → IDLE next cycle, no `mem_we`. A restarted 1-word load of 0x00000012 writes to addr 0.
